// File: rtl/sint_eq_drv_pkg.sv
// Shared types and constants for the signed-equality stimulus driver.
`default_nettype none

package sint_eq_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // x^7 + x^6 + 1 in a shift-left Fibonacci arrangement: feedback from bits 6 and 5
    localparam int LFSR_WIDTH = 7;
    localparam int LFSR_TAP_A = 6;
    localparam int LFSR_TAP_B = 5;

    typedef enum logic [1:0] {
        VC_EQUAL  = 2'd0,
        VC_LSB    = 2'd1,
        VC_SIGN   = 2'd2,
        VC_INVERT = 2'd3
    } vec_class_t;

    localparam int CNT_WIDTH = 8;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sint_lfsr.sv
// Fibonacci LFSR with synchronous seed load and single-step advance.
`default_nettype none

module sint_lfsr
    import sint_eq_drv_pkg::*;
#(
    parameter int               WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = 'h5A
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] step;

    // Only the upcoming value is exported: the operand registers load it on the same edge.
    always_comb begin
        step   = {lfsr_q[WIDTH-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (advance_i) begin
            lfsr_d = step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= RESET_VALUE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign next_o = step;

endmodule

`default_nettype wire

// File: rtl/sint_eq_stimulus_driver.sv
// Stimulus source and scoreboard for 7-bit signed equality comparator cells.
`default_nettype none

module sint_eq_stimulus_driver
    import sint_eq_drv_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter int               NUM_VECTORS = 16,
    parameter logic [WIDTH-1:0] SEED        = 'h5A,
    parameter int               TIMEOUT     = 15
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic                 start,
    output logic [WIDTH-1:0]     I0,
    output logic [WIDTH-1:0]     I1,
    output logic                 valid,
    input  logic                 ready,
    input  logic                 res_valid,
    input  logic                 res,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic                 timeout_err
);

    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [7:0]       LAST_K    = 8'(NUM_VECTORS - 1);
    localparam logic [7:0]       LAST_T    = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [7:0]             k_q, k_d;
    logic [7:0]             tcnt_q, tcnt_d;
    logic [WIDTH-1:0]       i0_q, i0_d;
    logic [WIDTH-1:0]       i1_q, i1_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   pass_q, pass_d;
    logic [CNT_WIDTH-1:0]   fail_q, fail_d;
    logic                   terr_q, terr_d;
    logic                   res_q, res_d;
    logic                   to_q, to_d;
    logic                   lfsr_load;
    logic                   lfsr_adv;
    logic [WIDTH-1:0]       lfsr_next;

    sint_lfsr #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (SEED)
    ) u_lfsr (
        .clk_i     (CLK),
        .rst_ni    (ASYNCRESETN),
        .load_i    (lfsr_load),
        .advance_i (lfsr_adv),
        .seed_i    (SEED),
        .next_o    (lfsr_next)
    );

    function automatic logic [WIDTH-1:0] form_i1(input logic [WIDTH-1:0] l, input vec_class_t c);
        case (c)
            VC_EQUAL: return l;
            VC_LSB:   return l ^ WIDTH'(1);
            VC_SIGN:  return l ^ SIGN_MASK;
            default:  return ~l;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tcnt_d    = tcnt_q;
        i0_d      = i0_q;
        i1_d      = i1_q;
        valid_d   = valid_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        terr_d    = terr_q;
        res_d     = res_q;
        to_d      = to_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_ISSUE;
                    pass_d    = '0;
                    fail_d    = '0;
                    terr_d    = 1'b0;
                    done_d    = 1'b0;
                    k_d       = '0;
                    lfsr_load = 1'b1;
                    i0_d      = SEED;
                    i1_d      = form_i1(SEED, VC_EQUAL);
                    valid_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (valid_q && ready) begin
                    state_d = ST_WAIT;
                    valid_d = 1'b0;
                    tcnt_d  = '0;
                end
            end
            ST_WAIT: begin
                // A result in the expiry cycle takes priority over the timeout.
                if (res_valid) begin
                    state_d = ST_CHECK;
                    res_d   = res;
                    to_d    = 1'b0;
                end else if (tcnt_q == LAST_T) begin
                    state_d = ST_CHECK;
                    res_d   = 1'b0;
                    to_d    = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (to_q) begin
                    fail_d = sat_inc(fail_q);
                    terr_d = 1'b1;
                end else if (res_q == (k_q[1:0] == VC_EQUAL)) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                end

                if (k_q == LAST_K) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_ISSUE;
                    k_d      = k_q + 8'd1;
                    lfsr_adv = 1'b1;
                    i0_d     = lfsr_next;
                    i1_d     = form_i1(lfsr_next, vec_class_t'(k_q[1:0] + 2'd1));
                    valid_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            tcnt_q  <= '0;
            i0_q    <= '0;
            i1_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            terr_q  <= 1'b0;
            res_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tcnt_q  <= tcnt_d;
            i0_q    <= i0_d;
            i1_q    <= i1_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            terr_q  <= terr_d;
            res_q   <= res_d;
            to_q    <= to_d;
        end
    end

    assign I0          = i0_q;
    assign I1          = i1_q;
    assign valid       = valid_q;
    assign done        = done_q;
    assign pass_count  = pass_q;
    assign fail_count  = fail_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);

endmodule

`default_nettype wire
